stencil_stim_window: RTL and testbench

Synthesizable, parametrised stimulus-and-capture harness for single-clock stencil accelerators such as harris, used in power-flow runs. It drives LANES independent pseudo-random input streams that advance on the accelerator's read enable. It sequences a configuration phase and a fixed-length measurement window, then exports a window flag that gates toggle/SAIF collection. It also folds the accelerator's output stream into a checksum and counters, so gate-level power runs are self-checking without a behavioural testbench.

---
 rtl/stencil_stim_window.sv | 143 ++++++++++++++
 tb/tb_stencil_stim_window.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stencil_stim_window.sv
// rtl/stencil_stim_window.sv - LFSR stimulus, CONFIG/RUN/DONE window sequencer and output capture
// Capture path (checksum, out_count, in_count) is built only when STENCIL_STIM_CAPTURE_EN is defined.
module stencil_stim_window #(
  parameter int          WIDTH         = 16,
  parameter int          LANES         = 1,
  parameter int          CONFIG_CYCLES = 409,
  parameter int          RUN_CYCLES    = 1000,
  parameter logic [31:0] SEED          = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   read_en,
  output logic [LANES*WIDTH-1:0] stim_data,
  input  logic                   write_valid,
  input  logic [LANES*WIDTH-1:0] write_data,
  output logic                   window_active,
  output logic                   done,
  output logic [31:0]            in_count,
  output logic [31:0]            out_count,
  output logic [31:0]            checksum
);

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] CONFIG_END = 32'(CONFIG_CYCLES - 1);
  localparam logic [31:0] RUN_END    = 32'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    CONFIG = 2'd0,
    RUN    = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] cnt, cnt_next;
  logic        restart;

  assign restart = rst || flush;

  function automatic logic [31:0] lane_seed(input int lane);
    logic [31:0] s;
    s = SEED ^ (32'(lane) * 32'h9E37_79B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  always_ff @(posedge clk) begin
    if (restart) begin
      state         <= CONFIG;
      cnt           <= 32'h0;
      window_active <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      window_active <= (state_next == RUN);
      done          <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 32'h1;
    case (state)
      CONFIG: begin
        if (cnt == CONFIG_END) begin
          state_next = RUN;
          cnt_next   = 32'h0;
        end
      end
      RUN: begin
        if (cnt == RUN_END) begin
          state_next = DONE;
          cnt_next   = 32'h0;
        end
      end
      default: begin
        state_next = DONE;
        cnt_next   = cnt;
      end
    endcase
  end

  // Lane LFSRs advance on read_en in every state so the stream stays aligned with the accelerator.
  logic [31:0] lfsr [LANES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (restart) begin
        lfsr[i] <= lane_seed(i);
      end else if (read_en) begin
        lfsr[i] <= lfsr_step(lfsr[i]);
      end
    end
  end

  always_comb begin
    stim_data = '0;
    for (int i = 0; i < LANES; i++) begin
      stim_data[i*WIDTH +: WIDTH] = lfsr[i][WIDTH-1:0];
    end
  end

`ifdef STENCIL_STIM_CAPTURE_EN
  logic [31:0] fold;

  always_comb begin
    fold = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      fold = fold ^ 32'(write_data[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      in_count  <= 32'h0;
      out_count <= 32'h0;
      checksum  <= 32'h0;
    end else begin
      if (window_active && write_valid) begin
        checksum <= {checksum[30:0], checksum[31]} ^ fold;
        if (out_count != 32'hFFFF_FFFF) begin
          out_count <= out_count + 32'h1;
        end
      end
      if (window_active && read_en && (in_count != 32'hFFFF_FFFF)) begin
        in_count <= in_count + 32'h1;
      end
    end
  end
`else
  logic unused_capture;

  assign unused_capture = ^{write_valid, write_data};
  assign in_count       = 32'h0;
  assign out_count      = 32'h0;
  assign checksum       = 32'h0;
`endif

endmodule

// File: tb/tb_stencil_stim_window.sv
// tb/tb_stencil_stim_window.sv - directed-vector bench for stencil_stim_window
// Capture expectations follow STENCIL_STIM_CAPTURE_EN; window/stimulus expectations are build-independent.
module tb_stencil_stim_window;

  localparam int          W    = 16;
  localparam int          L    = 2;
  localparam int          CC   = 4;
  localparam int          RC   = 8;
  localparam logic [31:0] SEED = 32'h0000_0001;
`ifdef STENCIL_STIM_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, flush, read_en, write_valid;
  logic [L*W-1:0] stim_data, write_data;
  logic           window_active, done;
  logic [31:0]    in_count, out_count, checksum;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m [L];

  stencil_stim_window #(
    .WIDTH(W), .LANES(L), .CONFIG_CYCLES(CC), .RUN_CYCLES(RC), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .read_en(read_en), .stim_data(stim_data),
    .write_valid(write_valid), .write_data(write_data), .window_active(window_active),
    .done(done), .in_count(in_count), .out_count(out_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    m[0] = 32'h0000_0001;
    m[1] = 32'h9E37_79B8;
  endtask

  function automatic logic [L*W-1:0] model_stim();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = m[i][W-1:0];
    return v;
  endfunction

  // Advance one clock; inputs set before the call apply to this edge, outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (rst || flush) model_reset();
    else if (read_en) for (int i = 0; i < L; i++) m[i] = step(m[i]);
  endtask

  task automatic do_reset(input logic re, input logic wv);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; read_en = re; write_valid = wv; write_data = 32'h0002_0003;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    vectors++; if (stim_data !== 32'h79B8_0001) begin miscompares++; $display("FAIL reset_stim got %h want %h", stim_data, 32'h79B8_0001); end
    vectors++; if (window_active !== 1'b0) begin miscompares++; $display("FAIL reset_window got %b want 0", window_active); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (in_count !== 32'h0) begin miscompares++; $display("FAIL reset_in_count got %0d want 0", in_count); end
    vectors++; if (out_count !== 32'h0) begin miscompares++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    vectors++; if (checksum !== 32'h0) begin miscompares++; $display("FAIL reset_checksum got %h want 0", checksum); end
  endtask

  task automatic test_lfsr();
    logic [15:0] exp_lane0 [3];
    exp_lane0[0] = 16'h0001; exp_lane0[1] = 16'h0003; exp_lane0[2] = 16'h0002;
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (stim_data[15:0] !== exp_lane0[k]) begin miscompares++; $display("FAIL lfsr_lane0_c%0d got %h want %h", k, stim_data[15:0], exp_lane0[k]); end
      vectors++; if (stim_data !== model_stim()) begin miscompares++; $display("FAIL lfsr_lanes_c%0d got %h want %h", k, stim_data, model_stim()); end
      tick();
    end
    read_en = 1'b0;
    tick();
    tick();
    vectors++; if (stim_data !== model_stim()) begin miscompares++; $display("FAIL lfsr_hold got %h want %h", stim_data, model_stim()); end
  endtask

  // Window timing, toggling read_en inside RUN and a constant write stream (fold = 3 ^ 2 = 1).
  task automatic test_window();
    int n;
    logic [31:0] exp_cs;
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      n = (k <= CC) ? 0 : ((k >= CC + RC) ? RC : k - CC);
      exp_cs = CAP ? ((32'h1 << n) - 32'h1) : 32'h0;
      vectors++; if (window_active !== (k >= CC && k < CC + RC)) begin miscompares++; $display("FAIL win_active_c%0d got %b", k, window_active); end
      vectors++; if (done !== (k >= CC + RC)) begin miscompares++; $display("FAIL win_done_c%0d got %b", k, done); end
      vectors++; if (window_active && done) begin miscompares++; $display("FAIL win_overlap_c%0d got 1 want 0", k); end
      vectors++; if (stim_data !== model_stim()) begin miscompares++; $display("FAIL win_stim_c%0d got %h want %h", k, stim_data, model_stim()); end
      vectors++; if (checksum !== exp_cs) begin miscompares++; $display("FAIL win_checksum_c%0d got %h want %h", k, checksum, exp_cs); end
      vectors++; if (out_count !== (CAP ? 32'(n) : 32'h0)) begin miscompares++; $display("FAIL win_out_count_c%0d got %0d want %0d", k, out_count, CAP ? n : 0); end
      vectors++; if (in_count !== (CAP ? 32'((n + 1) / 2) : 32'h0)) begin miscompares++; $display("FAIL win_in_count_c%0d got %0d want %0d", k, in_count, CAP ? (n + 1) / 2 : 0); end
      read_en = (k >= CC && k < CC + RC) ? ((k - CC) % 2 == 0) : 1'b1;
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < CC + 3; k++) tick();
    vectors++; if (window_active !== 1'b1) begin miscompares++; $display("FAIL flush_pre_window got %b want 1", window_active); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (window_active !== 1'b0) begin miscompares++; $display("FAIL flush_window got %b want 0", window_active); end
    vectors++; if (stim_data !== 32'h79B8_0001) begin miscompares++; $display("FAIL flush_stim got %h want %h", stim_data, 32'h79B8_0001); end
    vectors++; if (checksum !== 32'h0) begin miscompares++; $display("FAIL flush_checksum got %h want 0", checksum); end
    vectors++; if (out_count !== 32'h0) begin miscompares++; $display("FAIL flush_out_count got %0d want 0", out_count); end
    vectors++; if (in_count !== 32'h0) begin miscompares++; $display("FAIL flush_in_count got %0d want 0", in_count); end
    for (int j = 0; j < CC + RC + 2; j++) begin
      vectors++; if (window_active !== (j >= CC && j < CC + RC)) begin miscompares++; $display("FAIL flush_rerun_win_c%0d got %b", j, window_active); end
      vectors++; if (done !== (j >= CC + RC)) begin miscompares++; $display("FAIL flush_rerun_done_c%0d got %b", j, done); end
      tick();
    end
    vectors++; if (checksum !== (CAP ? 32'h0000_00FF : 32'h0)) begin miscompares++; $display("FAIL flush_rerun_checksum got %h", checksum); end
    vectors++; if (out_count !== (CAP ? 32'd8 : 32'd0)) begin miscompares++; $display("FAIL flush_rerun_out_count got %0d", out_count); end
    vectors++; if (in_count !== (CAP ? 32'd8 : 32'd0)) begin miscompares++; $display("FAIL flush_rerun_in_count got %0d", in_count); end
  endtask

  task automatic test_rst_and_flush();
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < CC + 5; k++) tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    vectors++; if (window_active !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL both_flags got %b%b want 00", window_active, done); end
    vectors++; if (stim_data !== 32'h79B8_0001) begin miscompares++; $display("FAIL both_stim got %h want %h", stim_data, 32'h79B8_0001); end
    vectors++; if (checksum !== 32'h0 || out_count !== 32'h0 || in_count !== 32'h0) begin miscompares++; $display("FAIL both_counts got %h/%0d/%0d want 0/0/0", checksum, out_count, in_count); end
    for (int k = 0; k < CC; k++) tick();
    vectors++; if (window_active !== 1'b1) begin miscompares++; $display("FAIL both_window_open got %b want 1", window_active); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; read_en = 1'b0; write_valid = 1'b0; write_data = '0;
    model_reset();
    test_reset();
    test_lfsr();
    test_window();
    test_flush();
    test_rst_and_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
